// File: rtl/uart_tx_param.sv
// uart_tx_param: UART transmitter with TX FIFO and a per-frame runtime configuration.
// Define UART_TX_CTS_EN to add the cts_n_i flow-control input.
module uart_tx_param #(
  parameter  int DATA_W     = 8,
  parameter  int FIFO_DEPTH = 8,
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              txd_o,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              fifo_full_o,
  output logic [CNT_W-1:0]  fifo_count_o,
  output logic              fifo_ovf_o,
  output logic              tx_mark_o,
  output logic              tx_idle_o,
  input  logic              cfg_en_i,
  input  logic [3:0]        cfg_data_len_i,
  input  logic [1:0]        cfg_parity_i,
  input  logic              cfg_two_stop_i,
  input  logic [15:0]       cfg_baud_div_i,
  input  logic [CNT_W-1:0]  cfg_watermark_i
`ifdef UART_TX_CTS_EN
  ,
  input  logic              cts_n_i
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_PARITY = 3'd4;
  localparam logic [2:0] S_STOP   = 3'd5;

  // XOR of the first len data bits, seeded with 1 for odd parity.
  function automatic logic frame_parity(input logic [DATA_W-1:0] data,
                                        input logic [3:0] len,
                                        input logic odd);
    logic p;
    p = odd;
    for (int i = 0; i < DATA_W; i++) begin
      p = p ^ (data[i] & (i < int'(len)));
    end
    return p;
  endfunction

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              ovf_q, mark_q;
  logic              empty_s, push_s, pop_s, cts_ok_s, bit_end_s;
  logic [3:0]        len_clamp_s;

  logic [2:0]        state_q, state_d;
  logic [15:0]       baud_q, baud_d, cnt_q, cnt_d;
  logic [3:0]        bit_q, bit_d, len_q, len_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_en_q, par_en_d, par_q, par_d;
  logic              two_stop_q, two_stop_d, stop2_q, stop2_d;
  logic              txd_q, txd_d;

`ifdef UART_TX_CTS_EN
  logic [1:0] cts_sync_q;

  // Two-flop synchroniser for the asynchronous clear-to-send input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cts_sync_q <= 2'b11;
    else        cts_sync_q <= {cts_sync_q[0], cts_n_i};
  end
  assign cts_ok_s = ~cts_sync_q[1];
`else
  assign cts_ok_s = 1'b1;
`endif

  assign fifo_full_o  = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty_s      = (count_q == {CNT_W{1'b0}});
  assign push_s       = wr_en_i & ~fifo_full_o;
  assign pop_s        = (state_q == S_IDLE) & cfg_en_i & ~empty_s & cts_ok_s;
  assign bit_end_s    = (cnt_q == 16'd0);
  assign fifo_count_o = count_q;
  assign fifo_ovf_o   = ovf_q;
  assign tx_mark_o    = mark_q;
  assign tx_idle_o    = (state_q == S_IDLE) & empty_s;
  assign txd_o        = txd_q;

  // FIFO storage; contents are meaningless after reset since the pointers restart.
  always_ff @(posedge clk) begin
    if (push_s) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // FIFO pointers, fill count, overflow pulse and watermark flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      ovf_q    <= 1'b0;
      mark_q   <= 1'b0;
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_s)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push_s) - CNT_W'(pop_s);
      ovf_q   <= wr_en_i & fifo_full_o;
      mark_q  <= (count_q < cfg_watermark_i);
    end
  end

  // Requested data length clamped into 5..DATA_W.
  always_comb begin
    if (cfg_data_len_i < 4'd5)                 len_clamp_s = 4'd5;
    else if (cfg_data_len_i > 4'(DATA_W))      len_clamp_s = 4'(DATA_W);
    else                                       len_clamp_s = cfg_data_len_i;
  end

  // Serial FSM next state; configuration is captured only in LOAD.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    len_d      = len_q;
    shift_d    = shift_q;
    par_en_d   = par_en_q;
    par_d      = par_q;
    two_stop_d = two_stop_q;
    stop2_d    = stop2_q;
    case (state_q)
      S_IDLE: begin
        if (pop_s) begin
          state_d = S_LOAD;
          shift_d = mem_q[rd_ptr_q];
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        state_d    = S_START;
        baud_d     = cfg_baud_div_i;
        cnt_d      = cfg_baud_div_i;
        len_d      = len_clamp_s;
        two_stop_d = cfg_two_stop_i;
        par_en_d   = (cfg_parity_i == 2'b01) | (cfg_parity_i == 2'b10);
        par_d      = frame_parity(shift_q, len_clamp_s, cfg_parity_i == 2'b10);
        bit_d      = 4'd0;
        stop2_d    = 1'b0;
      end
      S_START: begin
        if (bit_end_s) begin
          state_d = S_DATA;
          cnt_d   = baud_q;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_DATA: begin
        if (bit_end_s) begin
          cnt_d   = baud_q;
          shift_d = {1'b0, shift_q[DATA_W-1:1]};
          bit_d   = bit_q + 4'd1;
          if (bit_q == len_q - 4'd1) state_d = par_en_q ? S_PARITY : S_STOP;
          else                       state_d = S_DATA;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_PARITY: begin
        if (bit_end_s) begin
          state_d = S_STOP;
          cnt_d   = baud_q;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_STOP: begin
        if (bit_end_s) begin
          cnt_d = baud_q;
          if (two_stop_q & ~stop2_q) begin
            stop2_d = 1'b1;
            state_d = S_STOP;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Line level decoded from the current state, registered one cycle later.
  always_comb begin
    case (state_q)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shift_q[0];
      S_PARITY: txd_d = par_q;
      default:  txd_d = 1'b1;
    endcase
  end

  // Serial FSM state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      baud_q     <= 16'd0;
      cnt_q      <= 16'd0;
      bit_q      <= 4'd0;
      len_q      <= 4'd5;
      shift_q    <= {DATA_W{1'b0}};
      par_en_q   <= 1'b0;
      par_q      <= 1'b0;
      two_stop_q <= 1'b0;
      stop2_q    <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      len_q      <= len_d;
      shift_q    <= shift_d;
      par_en_q   <= par_en_d;
      par_q      <= par_d;
      two_stop_q <= two_stop_d;
      stop2_q    <= stop2_d;
      txd_q      <= txd_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboard bench for uart_tx_param: stimulus queues expected frames, a monitor
// decodes txd_o cycle by cycle and compares against them.
module tb_uart_tx_param;

  localparam int CNT_W = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        txd_o;
  logic        wr_en_i = 1'b0;
  logic [7:0]  wr_data_i = 8'h00;
  logic        fifo_full_o;
  logic [CNT_W-1:0] fifo_count_o;
  logic        fifo_ovf_o, tx_mark_o, tx_idle_o;
  logic        cfg_en_i = 1'b0;
  logic [3:0]  cfg_data_len_i = 4'd8;
  logic [1:0]  cfg_parity_i = 2'b00;
  logic        cfg_two_stop_i = 1'b0;
  logic [15:0] cfg_baud_div_i = 16'd3;
  logic [CNT_W-1:0] cfg_watermark_i = 4'd0;
`ifdef UART_TX_CTS_EN
  logic        cts_n_i = 1'b0;
`endif

  uart_tx_param #(.DATA_W(8), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .txd_o(txd_o),
    .wr_en_i(wr_en_i), .wr_data_i(wr_data_i),
    .fifo_full_o(fifo_full_o), .fifo_count_o(fifo_count_o), .fifo_ovf_o(fifo_ovf_o),
    .tx_mark_o(tx_mark_o), .tx_idle_o(tx_idle_o),
    .cfg_en_i(cfg_en_i), .cfg_data_len_i(cfg_data_len_i), .cfg_parity_i(cfg_parity_i),
    .cfg_two_stop_i(cfg_two_stop_i), .cfg_baud_div_i(cfg_baud_div_i),
    .cfg_watermark_i(cfg_watermark_i)
`ifdef UART_TX_CTS_EN
    , .cts_n_i(cts_n_i)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] data;
    int         len;
    bit         par_en;
    bit         par_bit;
    bit         two_stop;
    int         div;
  } frame_t;

  typedef struct {
    logic [3:0]  len_cfg;
    logic [1:0]  par_cfg;
    logic        two;
    logic [15:0] div;
    logic [7:0]  data;
    int          exp_len;
    bit          exp_pen;
    bit          exp_pbit;
  } vec_t;

  frame_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  bit mon_busy = 1'b0;
  bit gap_chk = 1'b0;
  bit have_prev = 1'b0;
  int cyc = 0;
  int end_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic void expect_frame(input logic [7:0] d, input int len, input bit pen,
                                       input bit pbit, input bit two, input int div);
    frame_t f;
    f.data = {1'b0, d}; f.len = len; f.par_en = pen; f.par_bit = pbit;
    f.two_stop = two; f.div = div;
    exp_q.push_back(f);
  endfunction

  task automatic write_byte(input logic [7:0] d);
    @(negedge clk); wr_en_i = 1'b1; wr_data_i = d;
    @(negedge clk); wr_en_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < budget) begin
      @(negedge clk); n++;
    end
    vectors++;
    if (n >= budget) begin
      miscompares++;
      $display("FAIL %s timeout: %0d frames pending, required 0", name, exp_q.size());
    end
  endtask

  task automatic wait_low(input int budget);
    int n;
    n = 0;
    while (txd_o !== 1'b0 && n < budget) begin
      @(negedge clk); n++;
    end
    vectors++;
    if (n >= budget) begin
      miscompares++;
      $display("FAIL start_timeout: txd_o=%b, required 0 within %0d cycles", txd_o, budget);
    end
  endtask

  // Monitor: on each start bit, pop the expected frame and check every cycle of every bit.
  initial begin : monitor
    frame_t f;
    logic   bits[$];
    logic   prev, seen;
    bit     abort, bad;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 1'b1;
      end else if (prev === 1'b1 && txd_o === 1'b0) begin
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_frame: start bit at cycle %0d, required none", cyc);
          prev = 1'b0;
        end else begin
          mon_busy = 1'b1;
          f = exp_q.pop_front();
          if (gap_chk && have_prev) begin
            vectors++;
            if (cyc - end_cyc - 1 != 2) begin
              miscompares++;
              $display("FAIL idle_gap: got %0d cycles, required 2", cyc - end_cyc - 1);
            end
          end
          bits = {};
          bits.push_back(1'b0);
          for (int i = 0; i < f.len; i++) bits.push_back(f.data[i]);
          if (f.par_en) bits.push_back(f.par_bit);
          bits.push_back(1'b1);
          if (f.two_stop) bits.push_back(1'b1);
          abort = 1'b0;
          for (int b = 0; b < bits.size() && !abort; b++) begin
            bad = 1'b0; seen = bits[b];
            for (int c = 0; c <= f.div && !abort; c++) begin
              if (b != 0 || c != 0) @(negedge clk);
              if (!rst_n) abort = 1'b1;
              else if (txd_o !== bits[b]) begin bad = 1'b1; seen = txd_o; end
            end
            if (!abort) begin
              vectors++;
              if (bad) begin
                miscompares++;
                $display("FAIL frame_bit %0d of data 0x%0h: txd_o=%b, required %b",
                         b, f.data, seen, bits[b]);
              end
            end
          end
          if (!abort) begin
            end_cyc = cyc;
            have_prev = gap_chk;
          end
          prev = abort ? 1'b1 : txd_o;
          mon_busy = 1'b0;
        end
      end else begin
        prev = txd_o;
      end
    end
  end

  vec_t vecs[7];

  initial begin : stimulus
    vecs[0] = '{4'd8,  2'b01, 1'b0, 16'd3, 8'hA5, 8, 1'b1, 1'b0};
    vecs[1] = '{4'd8,  2'b10, 1'b1, 16'd3, 8'hA5, 8, 1'b1, 1'b1};
    vecs[2] = '{4'd7,  2'b00, 1'b0, 16'd3, 8'hFF, 7, 1'b0, 1'b0};
    vecs[3] = '{4'd3,  2'b00, 1'b0, 16'd2, 8'h13, 5, 1'b0, 1'b0};
    vecs[4] = '{4'd8,  2'b11, 1'b0, 16'd0, 8'h5A, 8, 1'b0, 1'b0};
    vecs[5] = '{4'd15, 2'b01, 1'b1, 16'd0, 8'h81, 8, 1'b1, 1'b0};
    vecs[6] = '{4'd6,  2'b10, 1'b0, 16'd1, 8'h6B, 6, 1'b1, 1'b1};

    // Reset values
    repeat (3) @(negedge clk);
    chk("reset_txd", txd_o, 1);
    chk("reset_count", fifo_count_o, 0);
    chk("reset_full", fifo_full_o, 0);
    chk("reset_ovf", fifo_ovf_o, 0);
    chk("reset_mark", tx_mark_o, 0);
    chk("reset_idle", tx_idle_o, 1);
    rst_n = 1'b1;

    // 8N1, baud_div 3, 0xA5, with start latency check
    cfg_en_i = 1'b1;
    expect_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 3);
    write_byte(8'hA5);
    @(negedge clk);
    @(negedge clk);
    chk("latency_n2_high", txd_o, 1);
    @(negedge clk);
    chk("latency_n3_low", txd_o, 0);
    wait_done(200, "8n1");

    // Frame-format vectors
    foreach (vecs[k]) begin
      cfg_data_len_i = vecs[k].len_cfg;
      cfg_parity_i   = vecs[k].par_cfg;
      cfg_two_stop_i = vecs[k].two;
      cfg_baud_div_i = vecs[k].div;
      expect_frame(vecs[k].data, vecs[k].exp_len, vecs[k].exp_pen, vecs[k].exp_pbit,
                   vecs[k].two, int'(vecs[k].div));
      write_byte(vecs[k].data);
      wait_done(200, "format");
    end

    // Overflow: nine writes into a disabled transmitter
    cfg_en_i = 1'b0; cfg_data_len_i = 4'd8; cfg_parity_i = 2'b00;
    cfg_two_stop_i = 1'b0; cfg_baud_div_i = 16'd0;
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      wr_en_i = 1'b1; wr_data_i = 8'(i + 1);
      @(negedge clk);
      if (i == 6) chk("full_before_8th", fifo_full_o, 0);
      if (i == 7) chk("full_after_8th", fifo_full_o, 1);
    end
    wr_en_i = 1'b0;
    chk("ovf_pulse", fifo_ovf_o, 1);
    chk("count_full", fifo_count_o, 8);
    @(negedge clk);
    chk("ovf_one_cycle", fifo_ovf_o, 0);
    for (int i = 1; i <= 8; i++) expect_frame(8'(i), 8, 1'b0, 1'b0, 1'b0, 0);
    gap_chk = 1'b1;
    cfg_en_i = 1'b1;
    wait_done(400, "drain8");
    gap_chk = 1'b0;
    chk("idle_after_drain", tx_idle_o, 1);
    chk("count_after_drain", fifo_count_o, 0);

    // Watermark 3
    cfg_en_i = 1'b0; cfg_watermark_i = 4'd3;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      wr_en_i = 1'b1; wr_data_i = 8'h30 + 8'(i);
      @(negedge clk);
    end
    wr_en_i = 1'b0;
    chk("count_3", fifo_count_o, 3);
    chk("mark_from_count2", tx_mark_o, 1);
    @(negedge clk);
    chk("mark_from_count3", tx_mark_o, 0);
    for (int i = 0; i < 3; i++) expect_frame(8'h30 + 8'(i), 8, 1'b0, 1'b0, 1'b0, 0);
    cfg_en_i = 1'b1;
    wait_done(200, "mark_drain");
    @(negedge clk);
    chk("mark_empty", tx_mark_o, 1);
    cfg_watermark_i = 4'd0;

    // Mid-frame configuration change
    cfg_baud_div_i = 16'd3;
    expect_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 3);
    write_byte(8'h3C);
    wait_low(20);
    repeat (10) @(negedge clk);
    cfg_baud_div_i = 16'd1; cfg_parity_i = 2'b10; cfg_two_stop_i = 1'b1;
    expect_frame(8'h3C, 8, 1'b1, 1'b1, 1'b1, 1);
    write_byte(8'h3C);
    wait_done(300, "cfg_change");

    // Enable dropped mid-frame; second write coincides with the pop
    cfg_parity_i = 2'b00; cfg_two_stop_i = 1'b0;
    expect_frame(8'h11, 8, 1'b0, 1'b0, 1'b0, 1);
    @(negedge clk); wr_en_i = 1'b1; wr_data_i = 8'h11;
    @(negedge clk); wr_data_i = 8'h22;
    @(negedge clk); wr_en_i = 1'b0;
    chk("count_wr_pop", fifo_count_o, 1);
    wait_low(20);
    repeat (3) @(negedge clk);
    cfg_en_i = 1'b0;
    wait_done(200, "en_drop");
    repeat (30) @(negedge clk);
    chk("en_drop_count", fifo_count_o, 1);
    chk("en_drop_txd", txd_o, 1);
    chk("en_drop_not_idle", tx_idle_o, 0);
    expect_frame(8'h22, 8, 1'b0, 1'b0, 1'b0, 1);
    cfg_en_i = 1'b1;
    wait_done(200, "en_resume");
    chk("idle_after_resume", tx_idle_o, 1);

    // Reset in the middle of the data bits
    cfg_baud_div_i = 16'd3;
    expect_frame(8'h00, 8, 1'b0, 1'b0, 1'b0, 3);
    write_byte(8'h00);
    write_byte(8'h55);
    write_byte(8'h66);
    wait_low(20);
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_txd", txd_o, 1);
    chk("rst_mid_count", fifo_count_o, 0);
    chk("rst_mid_idle", tx_idle_o, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_done(50, "rst_abort");
    repeat (20) @(negedge clk);
    chk("post_rst_txd", txd_o, 1);
    expect_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 3);
    write_byte(8'h5A);
    wait_done(200, "post_rst");

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
